// File: rtl/program_store.sv
// rtl/program_store.sv - instruction store with run-time byte loader and HALT fill
module program_store #(
   parameter int         DEPTH   = 64,
   parameter logic [7:0] HALT_OP = 8'hC3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] instruction_address,
   output logic [7:0] instruction,
   input  logic       load_start,
   input  logic [7:0] load_data,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic       load_end,
   output logic       cpu_hold,
   output logic       load_done,
   output logic [7:0] load_count,
   output logic [7:0] checksum
);

   // The write pointer carries one extra bit so it can represent DEPTH itself.
   localparam int         AW          = $clog2(DEPTH);
   localparam int         AWP         = AW + 1;
   localparam logic [AW:0] LAST_WORD  = AWP'(DEPTH - 1);
   localparam logic [AW:0] WPTR_ONE   = AWP'(1);
   localparam logic [8:0]  DEPTH_LIMIT = 9'(DEPTH);

   typedef enum logic [1:0] {
      S_FILL,
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [AW:0] r_wptr;
   logic [AW:0] w_wptr_next;
   logic [7:0]  r_load_count;
   logic [7:0]  w_load_count_next;
   logic [7:0]  r_checksum;
   logic [7:0]  w_checksum_next;
   logic        r_load_ready;
   logic        w_load_ready_next;
   logic        r_cpu_hold;
   logic        r_load_done;
   logic [7:0]  r_instruction;
   logic [7:0]  w_fetch_data;
   logic        w_we;
   logic [7:0]  w_wdata;
   logic        w_accept;
   logic        w_addr_in_range;

   logic [7:0]  r_mem [DEPTH];

   // Next-state, pointer/counter updates and memory write request for the loader FSM
   always_comb begin
      w_state_next      = r_state;
      w_wptr_next       = r_wptr;
      w_load_count_next = r_load_count;
      w_checksum_next   = r_checksum;
      w_we              = 1'b0;
      w_wdata           = HALT_OP;
      w_accept          = 1'b0;

      case (r_state)
         S_FILL: begin
            // One HALT word per cycle until the last word has been written.
            if (r_wptr <= LAST_WORD) begin
               w_we        = 1'b1;
               w_wdata     = HALT_OP;
               w_wptr_next = r_wptr + WPTR_ONE;
               if (r_wptr == LAST_WORD) begin
                  w_state_next = S_DONE;
               end
            end else begin
               w_state_next = S_DONE;
            end
         end

         S_IDLE: begin
            if (load_start) begin
               w_state_next      = S_LOAD;
               w_wptr_next       = '0;
               w_load_count_next = 8'd0;
               w_checksum_next   = 8'd0;
            end
         end

         S_LOAD: begin
            w_accept = load_valid & r_load_ready;
            if (w_accept) begin
               w_we              = 1'b1;
               w_wdata           = load_data;
               w_wptr_next       = r_wptr + WPTR_ONE;
               w_load_count_next = r_load_count + 8'd1;
               w_checksum_next   = r_checksum + load_data;
               // A full store needs no fill; a same-cycle end still counts the byte.
               if (r_wptr == LAST_WORD) begin
                  w_state_next = S_DONE;
               end else if (load_end) begin
                  w_state_next = S_FILL;
               end
            end else if (load_end) begin
               if (r_wptr > LAST_WORD) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_FILL;
               end
            end
         end

         S_DONE: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_FILL;
         end
      endcase
   end

   // Ready is a registered decode of the state being entered, never of load_valid.
   always_comb begin
      w_load_ready_next = (w_state_next == S_LOAD) && (w_wptr_next <= LAST_WORD);
   end

   // Fetch data: memory contents only while serving in IDLE and in range, HALT otherwise
   always_comb begin
      w_addr_in_range = ({1'b0, instruction_address} < DEPTH_LIMIT);
      w_fetch_data    = HALT_OP;
      if ((r_state == S_IDLE) && w_addr_in_range) begin
         w_fetch_data = r_mem[instruction_address[AW-1:0]];
      end
   end

   // State, pointer, status and fetch registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_FILL;
         r_wptr        <= '0;
         r_load_count  <= 8'd0;
         r_checksum    <= 8'd0;
         r_load_ready  <= 1'b0;
         r_cpu_hold    <= 1'b1;
         r_load_done   <= 1'b0;
         r_instruction <= HALT_OP;
      end else begin
         r_state       <= w_state_next;
         r_wptr        <= w_wptr_next;
         r_load_count  <= w_load_count_next;
         r_checksum    <= w_checksum_next;
         r_load_ready  <= w_load_ready_next;
         r_cpu_hold    <= (w_state_next != S_IDLE);
         r_load_done   <= (w_state_next == S_DONE);
         r_instruction <= w_fetch_data;
      end
   end

   // Storage array: not reset, the post-reset fill establishes its contents
   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[r_wptr[AW-1:0]] <= w_wdata;
      end
   end

   assign instruction = r_instruction;
   assign load_ready  = r_load_ready;
   assign cpu_hold    = r_cpu_hold;
   assign load_done   = r_load_done;
   assign load_count  = r_load_count;
   assign checksum    = r_checksum;

endmodule

// File: tb/tb_program_store.sv
// tb/tb_program_store.sv - scoreboard bench for program_store
module tb_program_store;

   localparam int         DEPTH = 64;
   localparam logic [7:0] HALT  = 8'hC3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] instruction_address = 8'd0;
   logic [7:0] instruction;
   logic       load_start = 1'b0;
   logic [7:0] load_data = 8'd0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic       load_end = 1'b0;
   logic       cpu_hold;
   logic       load_done;
   logic [7:0] load_count;
   logic [7:0] checksum;

   always #5 clock = ~clock;

   program_store #(.DEPTH(DEPTH), .HALT_OP(HALT)) dut (
      .clock               (clock),
      .reset               (reset),
      .instruction_address (instruction_address),
      .instruction         (instruction),
      .load_start          (load_start),
      .load_data           (load_data),
      .load_valid          (load_valid),
      .load_ready          (load_ready),
      .load_end            (load_end),
      .cpu_hold            (cpu_hold),
      .load_done           (load_done),
      .load_count          (load_count),
      .checksum            (checksum)
   );

   typedef struct packed {
      logic [7:0]  cnt;
      logic [7:0]  sum;
      logic [15:0] run;
   } done_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_mem [DEPTH];
   logic [7:0] pb [128];
   logic [7:0] exp_fetch_q [$];
   done_t      done_q [$];
   done_t      d;
   logic       fetch_req   = 1'b0;
   logic       fetch_tag_d = 1'b0;
   int         run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   // Monitor: fetch responses one cycle after request, load_done against the done queue
   always @(posedge clock) fetch_tag_d <= fetch_req;

   always @(negedge clock) begin
      if (!reset) begin
         run = 0;
      end else begin
         if (fetch_tag_d) begin
            if (exp_fetch_q.size() == 0) fail_event("fetch_unexpected");
            else check("fetch", 32'(instruction), 32'(exp_fetch_q.pop_front()));
         end
         if (cpu_hold && !load_ready) run++;
         else run = 0;
         if (load_done) begin
            if (done_q.size() == 0) begin
               fail_event("done_unexpected");
            end else begin
               d = done_q.pop_front();
               check("done_count", 32'(load_count), 32'(d.cnt));
               check("done_checksum", 32'(checksum), 32'(d.sum));
               check("done_hold_cycles", 32'(run), 32'(d.run));
            end
         end
      end
   end

   task automatic fetch(input logic [7:0] a);
      @(negedge clock);
      instruction_address = a;
      fetch_req = 1'b1;
      if (32'(a) < DEPTH) exp_fetch_q.push_back(model_mem[int'(a)]);
      else exp_fetch_q.push_back(HALT);
   endtask

   task automatic fetch_all();
      fetch(8'd0);
      fetch(8'd37);
      for (int a = 0; a < DEPTH; a++) fetch(8'(a));
      fetch(8'd200);
      fetch(8'(DEPTH));
      fetch(8'hFF);
      @(negedge clock);
      fetch_req = 1'b0;
      @(negedge clock);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (cpu_hold && c < 300) begin
         @(negedge clock);
         c++;
      end
      check("idle_reached", 32'(cpu_hold), 32'd0);
   endtask

   // One load of n bytes from pb; expectations are pushed before the load starts
   task automatic do_load(input int n, input int gaps, input bit end_last, input bit poke_fill);
      int         k;
      int         waitc;
      bit         hs;
      logic [7:0] s;
      k = (n < DEPTH) ? n : DEPTH;
      s = 8'd0;
      for (int i = 0; i < k; i++) begin
         s += pb[i];
         model_mem[i] = pb[i];
      end
      for (int i = k; i < DEPTH; i++) model_mem[i] = HALT;
      done_q.push_back({8'(k), s, 16'(DEPTH - k + 1)});

      @(negedge clock);
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
            load_valid = 1'b0;
            load_data  = 8'($urandom);
            @(negedge clock);
         end
         load_valid = 1'b1;
         load_data  = pb[i];
         load_end   = end_last && (i == n - 1);
         waitc = 0;
         hs    = 1'b0;
         while (!hs && waitc < 8) begin
            if (load_ready) hs = 1'b1;
            @(negedge clock);
            waitc++;
         end
         if (!hs) break;
      end
      load_valid = 1'b0;
      load_end   = 1'b0;
      load_data  = 8'($urandom);
      if (!end_last && n < DEPTH) begin
         load_end = 1'b1;
         @(negedge clock);
         load_end = 1'b0;
      end
      if (poke_fill) begin
         @(negedge clock);
         @(negedge clock);
         load_start = 1'b1;
         @(negedge clock);
         load_start = 1'b0;
      end
      wait_idle();
      fetch_all();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit el;
      bit pf;

      // Reset state and the post-reset fill
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_instruction", 32'(instruction), 32'(HALT));
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_count", 32'(load_count), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT;
      done_q.push_back({8'd0, 8'd0, 16'(DEPTH + 1)});
      reset = 1'b1;
      wait_idle();
      fetch_all();

      // Directed three-byte program
      pb[0] = 8'h01;
      pb[1] = 8'h4C;
      pb[2] = 8'hC3;
      do_load(3, 0, 1'b0, 1'b0);

      // Alternating valid over four bytes
      for (int i = 0; i < 4; i++) pb[i] = 8'($urandom);
      do_load(4, 1, 1'b0, 1'b0);

      // Overflow: 70 offered, store takes DEPTH
      for (int i = 0; i < 70; i++) pb[i] = 8'($urandom);
      do_load(70, 0, 1'b0, 1'b0);

      // Byte and end in the same cycle, start pulse during the fill
      for (int i = 0; i < 5; i++) pb[i] = 8'($urandom);
      do_load(5, 0, 1'b1, 1'b1);

      // End pulse in IDLE is ignored
      @(negedge clock);
      load_end = 1'b1;
      @(negedge clock);
      load_end = 1'b0;
      repeat (3) @(negedge clock);
      check("idle_end_hold", 32'(cpu_hold), 32'd0);
      check("idle_end_ready", 32'(load_ready), 32'd0);

      // Randomized loads
      for (int t = 0; t < 6; t++) begin
         n  = int'($urandom_range(0, DEPTH + 6));
         el = (n > 0) && (n <= DEPTH) && ($urandom_range(0, 1) == 1);
         pf = (n + 8 <= DEPTH) && ($urandom_range(0, 1) == 1);
         for (int i = 0; i < n; i++) pb[i] = 8'($urandom);
         do_load(n, 2, el, pf);
      end

      // Reset in the middle of a load
      begin
         logic [7:0] s;
         s = 8'd0;
         for (int i = 0; i < 10; i++) begin
            pb[i] = 8'($urandom);
            s += pb[i];
         end
         @(negedge clock);
         load_start = 1'b1;
         @(negedge clock);
         load_start = 1'b0;
         for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = pb[i];
            @(negedge clock);
         end
         load_valid = 1'b1;
         load_data  = 8'($urandom);
         check("midload_count", 32'(load_count), 32'd10);
         check("midload_checksum", 32'(checksum), 32'(s));
         @(posedge clock);
         #2 reset = 1'b0;
         #1;
         check("arst_instruction", 32'(instruction), 32'(HALT));
         check("arst_cpu_hold", 32'(cpu_hold), 32'd1);
         check("arst_load_ready", 32'(load_ready), 32'd0);
         check("arst_load_done", 32'(load_done), 32'd0);
         check("arst_load_count", 32'(load_count), 32'd0);
         check("arst_checksum", 32'(checksum), 32'd0);
         load_valid = 1'b0;
         for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT;
         done_q.push_back({8'd0, 8'd0, 16'(DEPTH + 1)});
         repeat (2) @(posedge clock);
         #1 reset = 1'b1;
         wait_idle();
         fetch_all();
      end

      repeat (3) @(negedge clock);
      check("fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);
      check("done_q_empty", 32'(done_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
